// File: rtl/fpadd_pkg.sv
// Shared types and width helpers for the sequential IEEE-754 adder/subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, default-format widths, width helper functions,
// and the canonical quiet-NaN pattern generator.
package fpadd_pkg;

  typedef enum logic [2:0] {
    IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE
  } state_t;

  // Default format is IEEE half precision.
  localparam int EXP_W_DEF  = 5;
  localparam int FRAC_W_DEF = 10;

  function automatic int word_w(input int exp_w, input int frac_w);
    return 1 + exp_w + frac_w;
  endfunction

  // {carry, hidden, fraction, G, R, S}
  function automatic int mant_w(input int frac_w);
    return frac_w + 5;
  endfunction

  localparam int WORD_W  = word_w(EXP_W_DEF, FRAC_W_DEF);
  localparam int MANT_W  = mant_w(FRAC_W_DEF);
  localparam int EXP_MAX = (1 << EXP_W_DEF) - 1;

  // Canonical NaN {0, all-ones exponent, 1, 0...}, right-aligned in 64 bits;
  // callers size-cast to their word width.
  function automatic logic [63:0] canon_nan(input int exp_w, input int frac_w);
    logic [63:0] w;
    w = ((64'd1 << exp_w) - 64'd1) << frac_w;
    w = w | (64'd1 << (frac_w - 1));
    return w;
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even incrementer on {hidden, fraction, G, R, S}.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: mant = {hidden, FRAC_W fraction, G, R, S}; rounded = {hidden, fraction}
// after rounding; cout = carry out of the hidden bit.
module fp_round_rne
  import fpadd_pkg::*;
#(
  parameter int FRAC_W = 10
) (
  input  logic [FRAC_W+3:0] mant,
  output logic [FRAC_W:0]   rounded,
  output logic              cout
);

  localparam int SIG_W = mant_w(FRAC_W) - 4;  // hidden + fraction

  logic inc;

  // Ties (G=1, R=S=0) round up only when the kept lsb is odd.
  assign inc = mant[2] & (mant[1] | mant[0] | mant[3]);

  assign {cout, rounded} = {1'b0, mant[FRAC_W+3:3]} + {{SIG_W{1'b0}}, inc};

endmodule

// File: rtl/fp_addsub_seq.sv
// Iterative IEEE-754 adder/subtractor with RNE rounding, inf/NaN handling and flags.
// Latency: 2*FRAC_W+12 cycles worst case from St to Done; special operands finish early.
// Backpressure: St is only accepted in IDLE; pulses while Busy are dropped.
// Ports: CLK, RST (async, active-high); St/Sub/A/B request; Busy, Done pulse,
// Ovf/Unf/Zero flags and FPsum result, all held from Done until the next Done.
// Build option: define FPADD_DENORM_EN for gradual underflow; otherwise denormal
// inputs flush to zero and underflowing results become signed zero.
module fp_addsub_seq
  import fpadd_pkg::*;
#(
  parameter int EXP_W  = 5,
  parameter int FRAC_W = 10
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    St,
  input  logic                    Sub,
  input  logic [EXP_W+FRAC_W:0]   A,
  input  logic [EXP_W+FRAC_W:0]   B,
  output logic                    Busy,
  output logic                    Done,
  output logic                    Ovf,
  output logic                    Unf,
  output logic                    Zero,
  output logic [EXP_W+FRAC_W:0]   FPsum
);

  localparam int WW = word_w(EXP_W, FRAC_W);
  localparam int MW = mant_w(FRAC_W);
  localparam int EW = EXP_W + 1;                 // widened exponent, never wraps
  localparam logic [EW-1:0] EMAX  = EW'((1 << EXP_W) - 1);
  localparam logic [EW-1:0] E_ONE = EW'(1);
  localparam logic [EW-1:0] E_COLLAPSE = EW'(FRAC_W + 3);
  localparam logic [WW-1:0] NAN_W = WW'(canon_nan(EXP_W, FRAC_W));

  state_t state, state_nx;

  logic [WW-1:0] a_q, b_q;                       // b_q carries the effective sign
  logic          xs, ys;
  logic [EW-1:0] xe, ye;
  logic [MW-1:0] xm, ym;

  // ---------------- operand classification (UNPACK) ----------------
  logic              a_s, b_s;
  logic [EXP_W-1:0]  a_e, b_e;
  logic [FRAC_W-1:0] a_f, b_f;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_hid, b_hid;
  logic [EW-1:0]     a_ee, b_ee;
  logic [MW-1:0]     a_m, b_m;
  logic              swap, special;
  logic [WW-1:0]     spec_word;

  always_comb begin
    a_s = a_q[WW-1];
    b_s = b_q[WW-1];
    a_e = a_q[WW-2:FRAC_W];
    b_e = b_q[WW-2:FRAC_W];
    a_f = a_q[FRAC_W-1:0];
    b_f = b_q[FRAC_W-1:0];
    a_nan = (a_e == '1) & (|a_f);
    b_nan = (b_e == '1) & (|b_f);
    a_inf = (a_e == '1) & ~(|a_f);
    b_inf = (b_e == '1) & ~(|b_f);
`ifdef FPADD_DENORM_EN
    // Denormals: hidden 0, effective exponent 1.
    a_zero = (a_e == '0) & ~(|a_f);
    b_zero = (b_e == '0) & ~(|b_f);
    a_hid  = |a_e;
    b_hid  = |b_e;
    a_ee   = (a_e == '0) ? E_ONE : {1'b0, a_e};
    b_ee   = (b_e == '0) ? E_ONE : {1'b0, b_e};
`else
    // Flush-to-zero: any exp==0 operand counts as zero and never reaches ALIGN.
    a_zero = (a_e == '0);
    b_zero = (b_e == '0);
    a_hid  = 1'b1;
    b_hid  = 1'b1;
    a_ee   = {1'b0, a_e};
    b_ee   = {1'b0, b_e};
`endif
    a_m  = {1'b0, a_hid, a_f, 3'b000};
    b_m  = {1'b0, b_hid, b_f, 3'b000};
    swap = (b_ee > a_ee) | ((b_ee == a_ee) & (b_m > a_m));

    special   = 1'b1;
    spec_word = '0;
    if (a_nan | b_nan)                      spec_word = NAN_W;
    else if (a_inf & b_inf & (a_s != b_s))  spec_word = NAN_W;
    else if (a_inf)                         spec_word = a_q;
    else if (b_inf)                         spec_word = b_q;
    else if (a_zero & b_zero)               spec_word = {a_s & b_s, {(WW-1){1'b0}}};
    else if (a_zero)                        spec_word = b_q;
    else if (b_zero)                        spec_word = a_q;
    else                                    special   = 1'b0;
  end

  // ---------------- align / add / round helpers ----------------
  logic [EW-1:0]     diff;
  logic [MW-1:0]     add_m;
  logic [FRAC_W:0]   rnd_sig;
  logic              rnd_cout, rnd_hid, rnd_ovf;
  logic [EW-1:0]     rnd_e;

  assign diff  = xe - ye;
  // X >= Y after the swap, so the subtraction never goes negative.
  assign add_m = (xs == ys) ? (xm + ym) : (xm - ym);

  fp_round_rne #(.FRAC_W(FRAC_W)) u_rnd (
    .mant    (xm[MW-2:0]),
    .rounded (rnd_sig),
    .cout    (rnd_cout)
  );

  assign rnd_e   = rnd_cout ? (xe + E_ONE) : xe;
  assign rnd_hid = rnd_cout | rnd_sig[FRAC_W];   // 0 only for a denormal result
  assign rnd_ovf = (rnd_e >= EMAX);

  // ---------------- final result (one source per finishing state) ----------------
  logic          fin_vld, fin_ovf, fin_unf;
  logic [WW-1:0] fin_word;

  always_comb begin
    fin_vld  = 1'b0;
    fin_word = '0;
    fin_ovf  = 1'b0;
    fin_unf  = 1'b0;
    case (state)
      UNPACK: begin
        fin_vld  = special;
        fin_word = spec_word;
      end
      ADD: begin
        // Exact cancellation always yields +0.
        fin_vld = (xs != ys) & (add_m == '0);
      end
`ifndef FPADD_DENORM_EN
      NORM: begin
        if (!xm[MW-1] && !xm[MW-2] && (xe <= E_ONE)) begin
          fin_vld  = 1'b1;
          fin_word = {xs, {(WW-1){1'b0}}};
          fin_unf  = 1'b1;
        end
      end
`endif
      ROUND: begin
        fin_vld = 1'b1;
        if (rnd_ovf) begin
          fin_word = {xs, EMAX[EXP_W-1:0], {FRAC_W{1'b0}}};
          fin_ovf  = 1'b1;
        end else begin
          fin_word = {xs, (rnd_hid ? rnd_e[EXP_W-1:0] : {EXP_W{1'b0}}),
                      rnd_sig[FRAC_W-1:0]};
        end
        // Tiny (hidden still 0 before rounding) and inexact.
        fin_unf = ~xm[MW-2] & (|xm[2:0]);
      end
      default: ;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (St) state_nx = UNPACK;
      UNPACK: state_nx = fin_vld ? DONE : ALIGN;
      ALIGN:  if (xe == ye) state_nx = ADD;
      ADD:    state_nx = fin_vld ? DONE : NORM;
      NORM: begin
        if (fin_vld)                  state_nx = DONE;
        else if (xm[MW-1] | xm[MW-2]) state_nx = ROUND;
        else if (xe > E_ONE)          state_nx = NORM;
        else                          state_nx = ROUND;  // denormal result
      end
      ROUND:  state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state != IDLE);
    Done = (state == DONE);
  end

  // ---------------- datapath ----------------
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q   <= '0;
      b_q   <= '0;
      xs    <= 1'b0;
      ys    <= 1'b0;
      xe    <= '0;
      ye    <= '0;
      xm    <= '0;
      ym    <= '0;
      FPsum <= '0;
      Ovf   <= 1'b0;
      Unf   <= 1'b0;
      Zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (St) begin
            a_q <= A;
            b_q <= {B[WW-1] ^ Sub, B[WW-2:0]};
          end
        end
        UNPACK: begin
          if (swap) begin
            xs <= b_s;  xe <= b_ee;  xm <= b_m;
            ys <= a_s;  ye <= a_ee;  ym <= a_m;
          end else begin
            xs <= a_s;  xe <= a_ee;  xm <= a_m;
            ys <= b_s;  ye <= b_ee;  ym <= b_m;
          end
        end
        ALIGN: begin
          if (xe != ye) begin
            if (diff > E_COLLAPSE) begin
              // Every bit of Y lands beyond S: only the sticky survives.
              ym <= {{(MW-1){1'b0}}, |ym};
              ye <= xe;
            end else begin
              ym <= {1'b0, ym[MW-1:2], |ym[1:0]};
              ye <= ye + E_ONE;
            end
          end
        end
        ADD: xm <= add_m;
        NORM: begin
          if (xm[MW-1]) begin
            xm <= {1'b0, xm[MW-1:2], |xm[1:0]};
            xe <= xe + E_ONE;
          end else if (!xm[MW-2] && (xe > E_ONE)) begin
            xm <= {xm[MW-2:0], 1'b0};
            xe <= xe - E_ONE;
          end
        end
        default: ;
      endcase

      if (fin_vld) begin
        FPsum <= fin_word;
        Ovf   <= fin_ovf;
        Unf   <= fin_unf;
        Zero  <= ~(|fin_word[WW-2:0]);
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Self-checking bench for fp_addsub_seq in half precision: a directed vector
// table, then reset-abort and start-while-busy sequences.
module tb_fp_addsub_seq;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        St  = 1'b0;
  logic        Sub = 1'b0;
  logic [15:0] A   = '0;
  logic [15:0] B   = '0;
  logic        Busy, Done, Ovf, Unf, Zero;
  logic [15:0] FPsum;

  int n_pass  = 0;
  int n_total = 0;

  fp_addsub_seq #(.EXP_W(5), .FRAC_W(10)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .St    (St),
    .Sub   (Sub),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .Done  (Done),
    .Ovf   (Ovf),
    .Unf   (Unf),
    .Zero  (Zero),
    .FPsum (FPsum)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        ovf;
    logic        unf;
    logic        zero;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Issues one operation and waits (bounded) for Done; returns at the
  // negedge where Done is seen, or after the budget runs out.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output int lat);
    @(negedge CLK);
    A = a; B = b; Sub = s; St = 1'b1;
    @(negedge CLK);
    St = 1'b0;
    lat = 1;
    check("busy_after_st", 32'(Busy), 32'd1);
    while (Done !== 1'b1 && lat < 100) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          dones;
    logic [15:0] cap;
    logic [15:0] rst_b;

    // -------- reset state --------
    repeat (2) @(negedge CLK);
    check("rst_fpsum", 32'(FPsum), 32'h0);
    check("rst_done",  32'(Done),  32'h0);
    check("rst_busy",  32'(Busy),  32'h0);
    check("rst_flags", 32'({Ovf, Unf, Zero}), 32'h0);
    RST = 1'b0;

    // -------- vector table: a, b, sub, sum, ovf, unf, zero --------
    vecs.push_back(vec_t'{16'h3C00, 16'h3C00, 1'b0, 16'h4000, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{16'h8000, 16'h8000, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1});
    vecs.push_back(vec_t'{16'h3C01, 16'h1000, 1'b0, 16'h3C02, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{16'h3C00, 16'h1000, 1'b0, 16'h3C00, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 1'b0, 1'b0, 1'b0});
`ifdef FPADD_DENORM_EN
    vecs.push_back(vec_t'{16'h0400, 16'h0401, 1'b1, 16'h8001, 1'b0, 1'b0, 1'b0});
`else
    vecs.push_back(vec_t'{16'h0400, 16'h0401, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1});
`endif
    vecs.push_back(vec_t'{16'h4000, 16'h3C00, 1'b1, 16'h3C00, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{16'h3C00, 16'h4000, 1'b1, 16'hBC00, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{16'hC000, 16'h3C00, 1'b0, 16'hBC00, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{16'h0000, 16'h3C00, 1'b1, 16'hBC00, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{16'h3C00, 16'h1001, 1'b0, 16'h3C01, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{16'h3C00, 16'h1001, 1'b1, 16'h3BFF, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{16'h7BFF, 16'h4C00, 1'b0, 16'h7C00, 1'b1, 1'b0, 1'b0});
    vecs.push_back(vec_t'{16'hFC01, 16'h3C00, 1'b0, 16'h7E00, 1'b0, 1'b0, 1'b0});
    vecs.push_back(vec_t'{16'hFC00, 16'h3C00, 1'b1, 16'hFC00, 1'b0, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat);
      check($sformatf("vec%0d_done", i), 32'(Done), 32'd1);
      check($sformatf("vec%0d_sum", i), 32'(FPsum), 32'(vecs[i].sum));
      check($sformatf("vec%0d_ovf", i), 32'(Ovf), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_unf", i), 32'(Unf), 32'(vecs[i].unf));
      check($sformatf("vec%0d_zero", i), 32'(Zero), 32'(vecs[i].zero));
      check($sformatf("vec%0d_lat_le_32", i), 32'(lat <= 32), 32'd1);
      @(negedge CLK);
      check($sformatf("vec%0d_done_pulse", i), 32'(Done), 32'd0);
      check($sformatf("vec%0d_idle", i), 32'(Busy), 32'd0);
      check($sformatf("vec%0d_hold", i), 32'(FPsum), 32'(vecs[i].sum));
    end

    // -------- reset during ALIGN aborts the operation --------
    do_op(16'h3C00, 16'h3C00, 1'b0, lat);
    check("pre_rst_sum", 32'(FPsum), 32'h4000);
`ifdef FPADD_DENORM_EN
    rst_b = 16'h0001;
`else
    rst_b = 16'h1000;   // 0x0001 flushes to zero and would never align
`endif
    @(negedge CLK);
    A = 16'h3C00; B = rst_b; Sub = 1'b0; St = 1'b1;
    @(negedge CLK);     // UNPACK
    St = 1'b0;
    @(negedge CLK);     // ALIGN
    check("rst_mid_busy", 32'(Busy), 32'd1);
    RST = 1'b1;
    #1;
    check("rst_mid_fpsum", 32'(FPsum), 32'h0);
    check("rst_mid_busy0", 32'(Busy), 32'd0);
    check("rst_mid_done", 32'(Done), 32'd0);
    check("rst_mid_flags", 32'({Ovf, Unf, Zero}), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge CLK);
      if (Done) dones++;
    end
    check("rst_no_done", 32'(dones), 32'd0);
    do_op(16'h3C00, 16'h3C00, 1'b0, lat);
    check("post_rst_done", 32'(Done), 32'd1);
    check("post_rst_sum", 32'(FPsum), 32'h4000);
    @(negedge CLK);

    // -------- St while Busy is ignored --------
    @(negedge CLK);
    A = 16'h3C00; B = 16'h1000; Sub = 1'b0; St = 1'b1;
    @(negedge CLK);
    St = 1'b0;
    A = 16'h4000; B = 16'h4000; Sub = 1'b1;
    dones = 0;
    cap = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (Done) begin
        dones++;
        cap = FPsum;
      end
      St = Busy && (k < 24) && (k % 2 == 0);
    end
    St = 1'b0;
    check("busy_st_done_count", 32'(dones), 32'd1);
    check("busy_st_sum", 32'(cap), 32'h3C00);
    check("busy_st_idle", 32'(Busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
